// File: rtl/gs_matrix_io_pkg.sv
// Shared definitions for the Gaussian-elimination row memory loader/unloader.
package gs_matrix_io_pkg;

  localparam int unsigned K_DEFAULT          = 4;
  localparam int unsigned L_DEFAULT          = 4;
  localparam int unsigned READ_DELAY_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    KICK   = 3'd2,
    WAIT   = 3'd3,
    UNLOAD = 3'd4
  } gs_state_e;

endpackage

// File: rtl/gs_io_fifo.sv
// First-word-fall-through FIFO catching memory read data during unload.
module gs_io_fifo
  import gs_matrix_io_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop & ~empty;
  assign empty  = (count == '0);
  assign full   = (count == CNTW'(DEPTH));
  assign dout   = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) store[i] <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CNTW'(push) - CNTW'(do_pop);
    end
  end

endmodule

// File: rtl/gs_matrix_io.sv
// Loads k rows into the elimination memory, kicks the elimination engine,
// then streams the rows back out with credit-limited reads.
module gs_matrix_io
  import gs_matrix_io_pkg::*;
#(
  parameter int unsigned k          = K_DEFAULT,
  parameter int unsigned l          = L_DEFAULT,
  parameter int unsigned READ_DELAY = READ_DELAY_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [l-1:0]                         in_row,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [l-1:0]                         out_row,
  output logic                                 ge_start,
  input  logic                                 ge_done,
  output logic                                 mem_sel,
  output logic [((k > 1) ? $clog2(k) : 1)-1:0] mem_addr,
  output logic                                 mem_rw,
  output logic [l-1:0]                         mem_dout,
  input  logic [l-1:0]                         mem_din,
  output logic                                 busy
);

  localparam int unsigned AW      = (k > 1) ? $clog2(k) : 1;
  localparam int unsigned CW      = $clog2(k + 1);
  localparam int unsigned CREDITS = READ_DELAY + 1;
  localparam int unsigned CRW     = $clog2(CREDITS + 1);

  gs_state_e             state;
  logic [CW-1:0]         wcnt;
  logic [CW-1:0]         rcnt;
  logic [CW-1:0]         ocnt;
  logic [CRW-1:0]        credits;
  logic                  rd_issue_q;
  logic [READ_DELAY-1:0] rd_tag;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_c;
  logic                  issue_c;

  assign out_valid = ~fifo_empty;
  assign pop_c     = out_valid & out_ready;
  assign fifo_push = rd_tag[READ_DELAY-1];

  // The first read is issued on the same edge that leaves WAIT.
  assign issue_c = ((state == UNLOAD) || ((state == WAIT) && ge_done)) &&
                   (credits != '0) && (rcnt != CW'(k));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      ge_start   <= 1'b0;
      mem_sel    <= 1'b1;
      mem_addr   <= '0;
      mem_rw     <= 1'b0;
      mem_dout   <= '0;
      busy       <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      ocnt       <= '0;
      credits    <= CRW'(CREDITS);
      rd_issue_q <= 1'b0;
      rd_tag     <= '0;
    end else begin
      ge_start   <= 1'b0;
      rd_issue_q <= issue_c;
      credits    <= credits - CRW'(issue_c) + CRW'(pop_c);

      // rd_tag[i] marks that mem_din carries a requested row i+1 cycles after the address.
      rd_tag[0] <= rd_issue_q;
      for (int i = 1; i < int'(READ_DELAY); i++) rd_tag[i] <= rd_tag[i-1];

      if (issue_c) begin
        mem_addr <= rcnt[AW-1:0];
        rcnt     <= rcnt + CW'(1);
      end
      if (pop_c) ocnt <= ocnt + CW'(1);

      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          mem_rw <= 1'b0;
          if (in_valid && in_ready) begin
            mem_addr <= wcnt[AW-1:0];
            mem_rw   <= 1'b1;
            mem_dout <= in_row;
            wcnt     <= wcnt + CW'(1);
            if (wcnt == CW'(k - 1)) begin
              state    <= KICK;
              in_ready <= 1'b0;
            end
          end
        end
        KICK: begin
          ge_start <= 1'b1;
          mem_sel  <= 1'b0;
          mem_rw   <= 1'b0;
          mem_addr <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (ge_done) begin
            state   <= UNLOAD;
            mem_sel <= 1'b1;
          end
        end
        UNLOAD: begin
          if (pop_c && (ocnt == CW'(k - 1))) begin
            state   <= IDLE;
            busy    <= 1'b0;
            wcnt    <= '0;
            rcnt    <= '0;
            ocnt    <= '0;
            credits <= CRW'(CREDITS);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  gs_io_fifo #(
    .DEPTH(READ_DELAY + 1),
    .WIDTH(l)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (mem_din),
    .pop  (pop_c),
    .dout (out_row),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Credits bound outstanding reads plus buffered rows to the FIFO depth.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_gs_matrix_io.sv
// Scoreboard bench for gs_matrix_io with a behavioural memory and stub elimination engine.
module tb_gs_matrix_io;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_row;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_row;
  logic       ge_start;
  logic       ge_done;
  logic       mem_sel;
  logic [1:0] mem_addr;
  logic       mem_rw;
  logic [3:0] mem_dout;
  logic [3:0] mem_din;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;

  logic [3:0] exp_out[$];
  logic [5:0] exp_wr[$];

  logic [3:0] mem [4];
  logic [3:0] rd_pipe [2];

  gs_matrix_io #(.k(4), .l(4), .READ_DELAY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .ge_start (ge_start),
    .ge_done  (ge_done),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_rw   (mem_rw),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural memory: write on the edge, read data two cycles after the address.
  always @(posedge clk) begin
    if (mem_sel && mem_rw) mem[mem_addr] <= mem_dout;
    rd_pipe[0] <= mem[mem_addr];
    rd_pipe[1] <= rd_pipe[0];
  end
  assign mem_din = rd_pipe[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitors: output stream, memory writes, stall stability.
  logic       prev_stall = 1'b0;
  logic [3:0] prev_row   = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_row", 32'(out_row), 32'(prev_row));
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) fail_now("out_unexpected");
        else check("out_row", 32'(out_row), 32'(exp_out.pop_front()));
        pop_cnt++;
      end
      if (mem_sel && mem_rw) begin
        if (exp_wr.size() == 0) fail_now("mem_write_unexpected");
        else check("mem_write", 32'({mem_addr, mem_dout}), 32'(exp_wr.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_row   = out_row;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_row"},   32'(out_row),   32'd0);
    check({tag, "_ge_start"},  32'(ge_start),  32'd0);
    check({tag, "_mem_sel"},   32'(mem_sel),   32'd1);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_rw"},    32'(mem_rw),    32'd0);
    check({tag, "_mem_dout"},  32'(mem_dout),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // rows packed as {row3,row2,row1,row0}; gap idle cycles before each row.
  task automatic load(input logic [15:0] rows, input int gap);
    logic hs;
    int   n;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_row   = rows[4*i +: 4];
      exp_wr.push_back({2'(i), rows[4*i +: 4]});
      exp_out.push_back(rows[4*i +: 4]);
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 20) begin
        hs = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!hs) fail_now("load_handshake_timeout");
    end
    in_valid = 1'b0;
    in_row   = '0;
  endtask

  task automatic wait_ge_start();
    int n = 0;
    while (!ge_start && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ge_start) fail_now("ge_start_timeout");
  endtask

  // Pulse ge_done, then drain stop_after rows; bp selects the 1010 then 8x0 ready pattern.
  task automatic unload(input bit bp, input int stop_after, input bit strict);
    int base = pop_cnt;
    int cyc  = 0;
    int lat  = -1;
    ge_done = 1'b1;
    @(posedge clk); #1;
    ge_done = 1'b0;
    while ((pop_cnt - base) < stop_after && cyc < 200) begin
      if (bp) out_ready = (cyc < 4) ? (cyc % 2 == 0) : (cyc >= 12);
      else    out_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (lat < 0 && out_valid) lat = cyc;
    end
    if (cyc >= 200) fail_now("unload_timeout");
    if (strict) begin
      check("first_valid_latency", 32'(lat), 32'd3);
      check("busy_after_last", 32'(busy), 32'd0);
      check("valid_after_last", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b0;
    ge_done   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Back-to-back load, exact ge_start timing, streaming unload.
    load(16'h8421, 0);
    check("ge_start_early", 32'(ge_start), 32'd0);
    @(posedge clk); #1;
    check("ge_start_pulse", 32'(ge_start), 32'd1);
    check("mem_sel_kick", 32'(mem_sel), 32'd0);
    check("busy_kick", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("ge_start_one_cycle", 32'(ge_start), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    unload(1'b0, 4, 1'b1);

    // Gapped load, backpressured unload.
    load(16'hC35A, 2);
    wait_ge_start();
    repeat (10) @(posedge clk);
    #1;
    unload(1'b1, 4, 1'b0);
    check("busy_after_bp", 32'(busy), 32'd0);

    // ge_done during LOAD is ignored, then reset in the middle of unload.
    fork
      load(16'hB6D1, 1);
      begin
        repeat (3) @(posedge clk);
        #1 ge_done = 1'b1;
        @(posedge clk);
        #1 ge_done = 1'b0;
      end
    join
    wait_ge_start();
    repeat (6) @(posedge clk);
    #1;
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_out_valid", 32'(out_valid), 32'd0);
    check("wait_mem_sel", 32'(mem_sel), 32'd0);
    check("wait_mem_rw", 32'(mem_rw), 32'd0);
    check("wait_mem_addr", 32'(mem_addr), 32'd0);
    unload(1'b0, 2, 1'b0);
    rst = 1'b1;
    exp_out.delete();
    @(posedge clk); #1;
    check_reset("mid_unload_reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean run after the abort.
    load(16'h69E7, 0);
    wait_ge_start();
    repeat (10) @(posedge clk);
    #1;
    unload(1'b0, 4, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("exp_out_drained", 32'(exp_out.size()), 32'd0);
    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
